// File: rtl/svn_seg_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment patterns are active-low {a,b,c,d,e,f,g}.
package svn_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/svn_seg_dec.sv
// Nibble to active-low segment pattern; codes 10-15 blank
// unless HEX_MODE is set.
module svn_seg_dec
    import svn_seg_pkg::*;
#(
    parameter bit HEX_MODE = 1'b0
) (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = HEX_MODE ? SEG_A : SEG_BLANK;
            4'hB: seg = HEX_MODE ? SEG_B : SEG_BLANK;
            4'hC: seg = HEX_MODE ? SEG_C : SEG_BLANK;
            4'hD: seg = HEX_MODE ? SEG_D : SEG_BLANK;
            4'hE: seg = HEX_MODE ? SEG_E : SEG_BLANK;
            4'hF: seg = HEX_MODE ? SEG_F : SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/svn_seg_mux.sv
// Time-multiplexed N-digit common-anode driver with dead time,
// shadowed digit data and leading-zero blanking.
module svn_seg_mux
    import svn_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 2,
    parameter bit HEX_MODE    = 1'b0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] D,
    input  logic [NUM_DIGITS-1:0]   DP,
    input  logic                    LOAD,
    input  logic                    LZ_EN,
    output logic [7:0]              SEG,
    output logic [NUM_DIGITS-1:0]   AN
);

    localparam int PW = width_of(CLK_DIV);
    localparam int IW = width_of(NUM_DIGITS);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           pre;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] d_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic                    lz_q;

    logic                    upper_zero;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              nib;
    logic                    dp_cur;
    logic                    blank_cur;
    logic [6:0]              glyph;
    logic                    dead;
    logic [NUM_DIGITS-1:0]   an_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PRE_LAST) begin
            pre <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            d_q  <= '0;
            dp_q <= '0;
            lz_q <= 1'b0;
        end else if (LOAD) begin
            d_q  <= D;
            dp_q <= DP;
            lz_q <= LZ_EN;
        end
    end

    // Walk from the leftmost digit down; a digit blanks only
    // while every nibble at or above it is zero.
    always_comb begin
        upper_zero = 1'b1;
        lz_mask    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (d_q[4*k +: 4] == 4'h0);
            lz_mask[k] = lz_q & upper_zero & (k != 0);
        end
    end

    always_comb begin
        nib       = '0;
        dp_cur    = 1'b0;
        blank_cur = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib       = d_q[4*k +: 4];
                dp_cur    = dp_q[k];
                blank_cur = lz_mask[k];
            end
        end
    end

    svn_seg_dec #(
        .HEX_MODE(HEX_MODE)
    ) u_dec (
        .nib(nib),
        .seg(glyph)
    );

    assign dead = int'(pre) < DEAD_CYCLES;

    always_comb begin
        an_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_d[k] = !((idx == IW'(k)) && !dead);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            SEG <= 8'hFF;
            AN  <= '1;
        end else begin
            SEG <= {blank_cur ? SEG_BLANK : glyph, ~dp_cur};
            AN  <= an_d;
        end
    end

endmodule

// File: tb/tb_svn_seg_mux.sv
// Scoreboard bench: four driver variants share one stimulus
// stream and are checked against a behavioural display model.
module tb_svn_seg_mux;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        LOAD = 1'b0;
    logic        LZ_EN = 1'b0;
    logic [15:0] D = '0;
    logic [3:0]  DP = '0;

    logic [7:0] seg_a, seg_h, seg_z, seg_s;
    logic [3:0] an_a, an_h, an_z;
    logic [0:0] an_s;

    always #5 CLK = ~CLK;

    svn_seg_mux #(.NUM_DIGITS(4), .CLK_DIV(4), .DEAD_CYCLES(1), .HEX_MODE(1'b0)) u_a (
        .CLK(CLK), .RST(RST), .D(D), .DP(DP), .LOAD(LOAD), .LZ_EN(LZ_EN),
        .SEG(seg_a), .AN(an_a));

    svn_seg_mux #(.NUM_DIGITS(4), .CLK_DIV(4), .DEAD_CYCLES(1), .HEX_MODE(1'b1)) u_h (
        .CLK(CLK), .RST(RST), .D(D), .DP(DP), .LOAD(LOAD), .LZ_EN(LZ_EN),
        .SEG(seg_h), .AN(an_h));

    svn_seg_mux #(.NUM_DIGITS(4), .CLK_DIV(4), .DEAD_CYCLES(0), .HEX_MODE(1'b0)) u_z (
        .CLK(CLK), .RST(RST), .D(D), .DP(DP), .LOAD(LOAD), .LZ_EN(LZ_EN),
        .SEG(seg_z), .AN(an_z));

    svn_seg_mux #(.NUM_DIGITS(1), .CLK_DIV(4), .DEAD_CYCLES(1), .HEX_MODE(1'b0)) u_s (
        .CLK(CLK), .RST(RST), .D(D[3:0]), .DP(DP[0:0]), .LOAD(LOAD), .LZ_EN(LZ_EN),
        .SEG(seg_s), .AN(an_s));

    typedef struct packed {
        logic [3:0][7:0] seg;
        logic [3:0][3:0] an;
    } exp_t;

    exp_t        q[$];
    int          compared = 0;
    int          mismatched = 0;
    logic [6:0]  glyph[16];

    // Model state: cycles since reset plus the loaded display contents.
    int          t = 0;
    logic [15:0] sh_d = '0;
    logic [3:0]  sh_dp = '0;
    logic        sh_lz = 1'b0;

    function automatic void model(input int n, input int dead, input bit hex,
                                  output logic [7:0] seg, output logic [3:0] an);
        int pre, idx;
        logic [15:0] dm;
        logic [3:0] nb;
        logic [6:0] g;
        pre = t % 4;
        idx = (t / 4) % n;
        dm  = (n == 4) ? sh_d : (sh_d & 16'h000F);
        nb  = 4'(dm >> (4 * idx));
        an  = 4'hF;
        if (pre >= dead) an[idx] = 1'b0;
        g = (nb < 10 || hex) ? glyph[nb] : 7'h7F;
        if (sh_lz && idx != 0 && (dm >> (4 * idx)) == 0) g = 7'h7F;
        seg = {g, ~sh_dp[idx]};
    endfunction

    task automatic step(input logic rst, input logic ld, input logic [15:0] dv,
                        input logic [3:0] dpv, input logic lz);
        exp_t e;
        logic [7:0] s;
        logic [3:0] a;
        @(negedge CLK);
        RST = rst; LOAD = ld; D = dv; DP = dpv; LZ_EN = lz;
        if (rst) begin
            e.seg = '1;
            e.an  = '1;
        end else begin
            model(4, 1, 1'b0, s, a); e.seg[0] = s; e.an[0] = a;
            model(4, 1, 1'b1, s, a); e.seg[1] = s; e.an[1] = a;
            model(4, 0, 1'b0, s, a); e.seg[2] = s; e.an[2] = a;
            model(1, 1, 1'b0, s, a); e.seg[3] = s; e.an[3] = a;
        end
        q.push_back(e);
        if (rst) begin
            t = 0; sh_d = '0; sh_dp = '0; sh_lz = 1'b0;
        end else begin
            if (ld) begin
                sh_d = dv; sh_dp = dpv; sh_lz = lz;
            end
            t++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, D, DP, LZ_EN);
    endtask

    function automatic void chk(input string name, input logic [7:0] act,
                                input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endfunction

    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("seg_dec",  seg_a, e.seg[0]);
            chk("an_dec",   {4'hF, an_a}, {4'hF, e.an[0]});
            chk("seg_hex",  seg_h, e.seg[1]);
            chk("an_hex",   {4'hF, an_h}, {4'hF, e.an[1]});
            chk("seg_dead0", seg_z, e.seg[2]);
            chk("an_dead0", {4'hF, an_z}, {4'hF, e.an[2]});
            chk("seg_n1",   seg_s, e.seg[3]);
            chk("an_n1",    {5'h1F, 3'b111}, {5'h1F, e.an[3][3:1]});
            chk("an0_n1",   {7'h7F, an_s[0]}, {7'h7F, e.an[3][0]});
        end
    end

    initial begin
        glyph[0]  = 7'b0000001; glyph[1]  = 7'b1001111;
        glyph[2]  = 7'b0010010; glyph[3]  = 7'b0000110;
        glyph[4]  = 7'b1001100; glyph[5]  = 7'b0100100;
        glyph[6]  = 7'b0100000; glyph[7]  = 7'b0001111;
        glyph[8]  = 7'b0000000; glyph[9]  = 7'b0000100;
        glyph[10] = 7'b0001000; glyph[11] = 7'b1100000;
        glyph[12] = 7'b0110001; glyph[13] = 7'b1000010;
        glyph[14] = 7'b0110000; glyph[15] = 7'b0111000;

        repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        idle(6);

        step(1'b0, 1'b1, 16'h1234, 4'b0010, 1'b0);
        idle(24);

        step(1'b0, 1'b1, 16'h00A0, 4'b0000, 1'b1);
        idle(20);

        step(1'b0, 1'b1, 16'h0000, 4'b0000, 1'b1);
        idle(20);

        // Reload while digit 2 is mid-slot.
        for (int i = 0; i < 16 && (t % 16) != 9; i++) idle(1);
        step(1'b0, 1'b1, 16'h5678, 4'b1001, 1'b0);
        idle(20);

        // Reset pulse with idx=3, pre=2, carrying a LOAD it must override.
        for (int i = 0; i < 16 && (t % 16) != 14; i++) idle(1);
        step(1'b1, 1'b1, 16'h9999, 4'hF, 1'b1);
        idle(20);

        for (int i = 0; i < 500; i++) begin
            logic [15:0] dv;
            dv = 16'($urandom) >> (4 * $urandom_range(0, 4));
            step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, dv,
                 4'($urandom), 1'($urandom));
        end
        idle(4);

        repeat (2) @(posedge CLK);
        #2;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/svn_seg_mux.md
# svn_seg_mux

Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display. It holds a shadow copy of N BCD/hex nibbles plus decimal points and scans them onto one shared 8-bit segment bus with a one-hot anode select. It adds a refresh prescaler, anti-ghosting dead time, optional hex decode and leading-zero blanking. It sits between the measurement/status logic and the board display pins.

## Interface
- NUM_DIGITS, 4: digits scanned; ≥1.
- CLK_DIV, 50000: CLK cycles per digit slot; ≥2.
- DEAD_CYCLES, 2: cycles at the start of each slot with all anodes off; 0 ≤ DEAD_CYCLES < CLK_DIV.
- HEX_MODE, 0: 1 decodes nibbles A–F; 0 blanks codes 10–15.
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- D  in  4*NUM_DIGITS  digit nibbles; D[3:0] is digit 0 (rightmost).
- DP  in  NUM_DIGITS  decimal point per digit; 1 = lit.
- LOAD  in  1  captures D, DP and LZ_EN into the shadow registers.
- LZ_EN  in  1  leading-zero suppression enable.
- SEG  out  8  {a,b,c,d,e,f,g,dp}, MSB = a, active-low, registered.
- AN  out  NUM_DIGITS  anode enables, active-low, one-hot-low, registered.

## Operation
- Shadow regs d_q, dp_q, lz_q load on any cycle with LOAD=1. The display never reads D/DP directly, so it cannot tear mid-scan.
- Prescaler pre runs 0..CLK_DIV-1 and wraps. At pre == CLK_DIV-1, digit index idx advances: idx == NUM_DIGITS-1 wraps to 0.
- Decode, active-low {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - With HEX_MODE=1: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - Otherwise 10–15 give 1111111.
- SEG[0] = ~dp_q[idx].
- Leading-zero blanking applies when lz_q=1. Digit k is blank (SEG[7:1]=1111111) if nibbles k..NUM_DIGITS-1 are all zero and k ≠ 0. Digit 0 always shows. DP is unaffected by blanking.
- AN[idx] = 0 when pre ≥ DEAD_CYCLES. All other AN bits are 1. All AN bits are 1 while pre < DEAD_CYCLES.
- Each cycle, SEG is updated with the pattern for the current idx.

## Timing
- Reset values: pre=0, idx=0, d_q=0, dp_q=0, lz_q=0, SEG=8'hFF, AN all 1s.
- SEG and AN reflect the (pre, idx, shadow) state of the previous cycle: one-cycle registered latency.
- LOAD at edge n updates the shadow at n. SEG reflects it at edge n+1 if the digit is currently selected, otherwise at that digit's next slot.
- LOAD on the same cycle as an idx advance: the new digit shows new data one cycle later, with no mix of old and new.
- Slot period is CLK_DIV cycles. Full frame is NUM_DIGITS*CLK_DIV cycles. Anode on-time per slot is CLK_DIV-DEAD_CYCLES.
- With DEAD_CYCLES=0, AN switches directly between digits on the wrap cycle.
- NUM_DIGITS=1: idx is constant 0 and AN[0] follows the dead-time rule only.
- RST asserted mid-scan: next edge restores all reset values, and the scan restarts at digit 0, pre=0. RST overrides LOAD.
- Counter widths: pre uses $clog2(CLK_DIV); idx uses max(1,$clog2(NUM_DIGITS)).

## Structure
- Package svn_seg_pkg holds:
  - the 16 segment pattern constants;
  - SEG_BLANK = 7'b1111111;
  - a function for clog2-safe widths.
- Sub-module svn_seg_dec: combinational nibble → 7-bit pattern with HEX_MODE parameter. Instantiated once, on the muxed nibble.
- Top holds the prescaler, index counter, shadow registers, LZ mask, and output registers.

## Test plan
Bench parameters: NUM_DIGITS=4, CLK_DIV=4, DEAD_CYCLES=1 unless noted.
- RST held 3 cycles, then released → SEG=8'hFF and AN=4'b1111 during reset. First post-reset cycles show AN=4'b1111 for 1 cycle, then 4'b1110 for 3 cycles.
- LOAD D=16'h1234, DP=4'b0010, LZ_EN=0 → slots cycle digit 0..3:
  - digit 0: SEG=8'b10011001 (4);
  - digit 1: SEG=8'b00001100 (3, dp lit);
  - digit 2: SEG=8'b00100101 (2);
  - digit 3: SEG=8'b10011111 (1);
  - then wrap to digit 0.
- D=16'h00A0, LZ_EN=1:
  - HEX_MODE=0 → digit 1 SEG=8'hFF, digits 2–3 blank, digit 0 shows 0 (8'b00000011).
  - HEX_MODE=1 → digit 1 shows A (8'b00010001), digits 2–3 blank.
- LZ_EN=1, D=0 → only digit 0 lit (0). Digits 1–3 SEG=8'hFF, while their AN still scans.
- LOAD new value mid-slot of digit 2 → SEG changes exactly one cycle after LOAD. Other digits update at their next slots, with no glitch in AN.
- RST pulse while idx=3, pre=2 → next cycle SEG=8'hFF, AN=4'b1111, and the scan resumes at digit 0. Repeat with DEAD_CYCLES=0, and with NUM_DIGITS=1 (AN stays 0 outside dead time).
